grid_io_cfg_loader: RTL and testbench
=====================================

Name: grid_io_cfg_loader

Overview:
- Sequencer that programs the memory-bank configuration port of a grid I/O tile: the 1-bit `enable`, the address bus and the 1-bit `data_in`.
- Accepts a serial bitstream over a valid/ready handshake and writes each bit to the next configuration address in a fixed order.
- Each write uses a setup/strobe/hold timing pattern.
- Sits between the configuration-protocol front end and one grid_io tile row.

Parameters:
- NUM_TILES, 8, I/O sub-tiles behind the tile decoder (power of 2).
- BITS_PER_TILE, 2, configuration bits per sub-tile (power of 2).
- TILE_AW, 3, log2(NUM_TILES); width of the decoder address field.
- BIT_AW, 1, log2(BITS_PER_TILE); width of the in-tile bit select.

Ports:
- prog_clk  in  1  configuration clock; all logic on rising edge.
- prog_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; honoured only in IDLE.
- abort  in  1  cancel the load in progress.
- bs_valid  in  1  bitstream bit valid.
- bs_data  in  1  bitstream bit.
- bs_ready  out  1  loader can accept a bit.
- cfg_enable  out  1  write strobe to the tile decoder enable.
- cfg_address  out  [0:BIT_AW+TILE_AW-1]  bits [0:BIT_AW-1] = in-tile bit select; remaining bits = tile index, driven to the decoder address.
- cfg_data_in  out  1  configuration data bit.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky parity error; exists only when IO_CFG_PARITY_EN is defined.

Behaviour:
- Reset (prog_rst_n low, asynchronous): state IDLE, counter 0. All outputs 0: cfg_enable, cfg_address, cfg_data_in, bs_ready, busy, done, error.
- States: IDLE, FETCH, SETUP, STROBE, HOLD, (PARITY), DONE.
- IDLE:
  - start=1 → FETCH; counter cleared.
  - busy=0 in IDLE; busy=1 in every other state except DONE.
- FETCH:
  - bs_ready=1.
  - On bs_valid&&bs_ready: capture bs_data → SETUP.
  - No valid → stay in FETCH indefinitely.
- SETUP: cfg_address and cfg_data_in driven from the counter and the captured bit; cfg_enable=0.
- STROBE: cfg_enable=1 for exactly one cycle; address and data unchanged.
- HOLD:
  - cfg_enable=0; address and data unchanged.
  - If counter == NUM_TILES*BITS_PER_TILE-1 → DONE (or PARITY when the macro is defined).
  - Otherwise counter+1 → FETCH.
- Address order:
  - Counter c, 0..NUM_TILES*BITS_PER_TILE-1.
  - Bit select = c mod BITS_PER_TILE; tile index = c / BITS_PER_TILE.
  - With defaults: tile0 bit0, tile0 bit1, tile1 bit0, … tile7 bit1.
  - The counter never wraps within a load.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency (defaults): each bit takes 4 cycles with bs_valid held high, so 16 bits take 64 cycles. done is high in the 65th cycle after the edge that samples start.
- cfg_address and cfg_data_in keep their last value between writes. They return to 0 only on reset or abort.
- abort (any non-IDLE state):
  - Next state IDLE; cfg_enable=0 on the next cycle.
  - Address and data cleared; done is not pulsed.
  - An abort during STROBE cuts the strobe at that edge.
- abort and start in the same IDLE cycle: abort wins; stay in IDLE.
- start while busy: ignored.
- bs_ready is 0 in every state except FETCH; a bit offered outside FETCH is not consumed.

Optional Feature:
- Macro: IO_CFG_PARITY_EN.
- Defined:
  - After the last HOLD, enter PARITY with bs_ready=1 and accept one extra bit.
  - The extra bit must equal the XOR of all loaded bits (even parity).
  - Mismatch sets error=1. error stays set until the next accepted start or reset.
  - Then go to DONE; done pulses regardless of the parity result.
- Not defined: no PARITY state and no error port; HOLD of the last bit goes directly to DONE.

Decomposition:
- Shared package grid_io_cfg_pkg holds:
  - the state enum;
  - NUM_CFG_BITS = NUM_TILES*BITS_PER_TILE;
  - the address-split helper function.
- Natural sub-module grid_io_cfg_addr_gen: counter with clear/increment/last flag, and the cfg_address mapping.

Test Plan:
- Reset mid-load (prog_rst_n low during STROBE of bit 5) → cfg_enable=0 immediately (asynchronously); all outputs 0; next start reloads from address 0.
- Full load, bs_valid always 1, data 16'b1010_0000_1111_0011 (bit0 first) → 16 one-cycle strobes at addresses in order tile0b0..tile7b1, each with the matching cfg_data_in; done pulses 65 cycles after start.
- Throttled source, bs_valid low for 3 cycles before every bit → bs_ready held in FETCH; no strobe while waiting; every strobe still has 1 setup cycle and 1 hold cycle.
- Abort asserted during STROBE of bit 7 → IDLE next cycle; no done; address cleared. Start together with abort in IDLE → remains IDLE.
- Start pulsed repeatedly during a load → ignored; exactly 16 strobes and a single done.
- IO_CFG_PARITY_EN defined, all-ones bitstream (16 ones, parity 0) with parity bit 0 → error=0. Same load with parity bit 1 → error=1 held until the next start.

Source files
------------

// File: rtl/grid_io_cfg_pkg.sv
// -----------------------------------------------------------------------------
// grid_io_cfg_pkg
// Shared definitions for the grid I/O configuration loader:
//   - tile geometry (NUM_TILES, BITS_PER_TILE and their address widths)
//   - NUM_CFG_BITS, the number of configuration bits written per load
//   - FSM state encodings (legacy-compatible localparam constants)
//   - cfg_addr_map: splits the write counter into {bit select, tile index}
//   - par_next: running even-parity accumulator step
// Optional feature macro used by the loader: IO_CFG_PARITY_EN.
// -----------------------------------------------------------------------------
package grid_io_cfg_pkg;

  localparam int NUM_TILES     = 8;
  localparam int BITS_PER_TILE = 2;
  localparam int TILE_AW       = 3;
  localparam int BIT_AW        = 1;

  localparam int NUM_CFG_BITS  = NUM_TILES * BITS_PER_TILE;
  localparam int CNT_W         = TILE_AW + BIT_AW;
  localparam int ADDR_W        = BIT_AW + TILE_AW;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CFG_BITS - 1);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_STROBE = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_PARITY = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  // The bit select occupies the leftmost (lowest-numbered) bits of the
  // ascending cfg_address port, so it goes first in the packed value.
  function automatic logic [ADDR_W-1:0] cfg_addr_map(input logic [CNT_W-1:0] cnt);
    logic [BIT_AW-1:0]  bit_sel;
    logic [TILE_AW-1:0] tile_idx;
    bit_sel  = cnt[BIT_AW-1:0];
    tile_idx = cnt[CNT_W-1:BIT_AW];
    return {bit_sel, tile_idx};
  endfunction

  function automatic logic par_next(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

endpackage

// File: rtl/grid_io_cfg_addr_gen.sv
// -----------------------------------------------------------------------------
// grid_io_cfg_addr_gen
// Write counter for the configuration loader plus the counter-to-address map.
// Ports:
//   i_clk    in   configuration clock
//   i_rst_n  in   asynchronous active-low reset
//   i_clr    in   clear the counter to 0 (wins over i_inc)
//   i_inc    in   advance to the next configuration bit
//   o_last   out  counter is at the final configuration bit
//   o_addr   out  {bit select, tile index} for the current counter value
// -----------------------------------------------------------------------------
module grid_io_cfg_addr_gen
  import grid_io_cfg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_addr
);

  logic [CNT_W-1:0] r_cnt;

  // Bit counter: cleared per load, saturates at the last bit so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && !o_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == LAST_CNT);
  assign o_addr = cfg_addr_map(r_cnt);

endmodule

// File: rtl/grid_io_cfg_loader.sv
// -----------------------------------------------------------------------------
// grid_io_cfg_loader
// Streams a serial bitstream into the memory-bank configuration port of a
// grid I/O tile row. Each accepted bit is written with a setup / one-cycle
// strobe / hold pattern at the next address (tile0 bit0, tile0 bit1, ...).
// Optional feature: define IO_CFG_PARITY_EN to accept a trailing even-parity
// bit after the last write and report a mismatch on the sticky error output.
// Ports:
//   prog_clk     in   configuration clock (rising edge)
//   prog_rst_n   in   asynchronous active-low reset
//   start        in   begin a load (honoured only when idle)
//   abort        in   cancel the load in progress
//   bs_valid     in   bitstream bit valid
//   bs_data      in   bitstream bit
//   bs_ready     out  loader can accept a bit
//   cfg_enable   out  write strobe to the tile decoder
//   cfg_address  out  [0:BIT_AW-1] bit select, remaining bits tile index
//   cfg_data_in  out  configuration data bit
//   busy         out  load in progress
//   done         out  one-cycle pulse on successful completion
//   error        out  sticky parity error (IO_CFG_PARITY_EN only)
// All outputs are registered.
// -----------------------------------------------------------------------------
module grid_io_cfg_loader
  import grid_io_cfg_pkg::*;
(
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  input  logic              bs_data,
  output logic              bs_ready,
  output logic              cfg_enable,
  output logic [0:ADDR_W-1] cfg_address,
  output logic              cfg_data_in,
  output logic              busy,
  output logic              done
`ifdef IO_CFG_PARITY_EN
  ,
  output logic              error
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_bs_ready;
  logic              r_cfg_enable;
  logic [ADDR_W-1:0] r_cfg_address;
  logic              r_cfg_data_in;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_capture;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ready_nxt;
`ifdef IO_CFG_PARITY_EN
  logic              w_par_chk;
  logic              w_start_acc;
  logic              r_parity;
  logic              r_error;
`endif

  assign w_accept = bs_valid & r_bs_ready;

  grid_io_cfg_addr_gen u_addr_gen (
    .i_clk   (prog_clk),
    .i_rst_n (prog_rst_n),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_last  (w_last),
    .o_addr  (w_addr)
  );

  // Next-state and datapath control; abort overrides everything, including start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
`ifdef IO_CFG_PARITY_EN
    w_par_chk   = 1'b0;
`endif
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_FETCH;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (w_accept) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_SETUP:  w_state_nxt = ST_STROBE;
        ST_STROBE: w_state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (w_last) begin
`ifdef IO_CFG_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
`ifdef IO_CFG_PARITY_EN
        ST_PARITY: begin
          if (w_accept) begin
            w_par_chk   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_PARITY;
          end
        end
`endif
        ST_DONE:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The loader takes bitstream bits only while fetching (and for the parity bit).
  always_comb begin
`ifdef IO_CFG_PARITY_EN
    w_ready_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_PARITY);
`else
    w_ready_nxt = (w_state_nxt == ST_FETCH);
`endif
  end

  // State register and state-decoded outputs, registered from the next state.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state      <= ST_IDLE;
      r_bs_ready   <= 1'b0;
      r_cfg_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bs_ready   <= w_ready_nxt;
      r_cfg_enable <= (w_state_nxt == ST_STROBE);
      r_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  // Address/data are loaded when a bit is accepted and held until the next bit or abort.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_cfg_address <= {ADDR_W{1'b0}};
      r_cfg_data_in <= 1'b0;
    end else if (abort) begin
      r_cfg_address <= {ADDR_W{1'b0}};
      r_cfg_data_in <= 1'b0;
    end else if (w_capture) begin
      r_cfg_address <= w_addr;
      r_cfg_data_in <= bs_data;
    end else begin
      r_cfg_address <= r_cfg_address;
      r_cfg_data_in <= r_cfg_data_in;
    end
  end

`ifdef IO_CFG_PARITY_EN
  assign w_start_acc = start & ~abort & (r_state == ST_IDLE);

  // Running parity of loaded bits and sticky error, both cleared by an accepted start.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_parity <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_start_acc) begin
      r_parity <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_capture) begin
      r_parity <= par_next(r_parity, bs_data);
      r_error  <= r_error;
    end else if (w_par_chk && (bs_data != r_parity)) begin
      r_parity <= r_parity;
      r_error  <= 1'b1;
    end else begin
      r_parity <= r_parity;
      r_error  <= r_error;
    end
  end

  assign error = r_error;
`endif

  assign bs_ready    = r_bs_ready;
  assign cfg_enable  = r_cfg_enable;
  assign cfg_address = r_cfg_address;
  assign cfg_data_in = r_cfg_data_in;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_grid_io_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_grid_io_cfg_loader
// Self-checking bench for grid_io_cfg_loader. Whole loads come from a table of
// {bitstream, source gap, start-spam, parity bit, expected error} records;
// every accepted bit pushes its expected {address, data} onto a scoreboard that
// is popped on each observed write strobe. Abort, start+abort and reset during
// a strobe are hand-written sequences. Build with +define+IO_CFG_PARITY_EN to
// exercise the parity bit.
// -----------------------------------------------------------------------------
module tb_grid_io_cfg_loader;

  typedef struct {
    logic [15:0] bits;
    int          gap;
    logic        spam;
    logic        par;
    logic        exp_err;
  } vec_t;

  logic       prog_clk;
  logic       prog_rst_n;
  logic       start;
  logic       abort;
  logic       bs_valid;
  logic       bs_data;
  logic       bs_ready;
  logic       cfg_enable;
  logic [0:3] cfg_address;
  logic       cfg_data_in;
  logic       busy;
  logic       done;
`ifdef IO_CFG_PARITY_EN
  logic       error;
  logic       last_err;
`endif

  int         n_tests;
  int         n_fail;
  int         cyc;
  int         n_strobe;
  int         n_done;
  int         done_cyc;
  logic       prev_en;
  logic       prev_done;
  logic [4:0] prev_wr;
  logic       hold_pend;
  logic [4:0] hold_exp;
  logic [4:0] sb[$];
  vec_t       vecs[$];

  grid_io_cfg_loader dut (
    .prog_clk    (prog_clk),
    .prog_rst_n  (prog_rst_n),
    .start       (start),
    .abort       (abort),
    .bs_valid    (bs_valid),
    .bs_data     (bs_data),
    .bs_ready    (bs_ready),
    .cfg_enable  (cfg_enable),
    .cfg_address (cfg_address),
    .cfg_data_in (cfg_data_in),
    .busy        (busy),
    .done        (done)
`ifdef IO_CFG_PARITY_EN
    ,
    .error       (error)
`endif
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Hang guard: a stuck run still reports and stops.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected write for bit k: bit select = k mod 2, tile = k / 2, then data.
  function automatic logic [4:0] exp_wr(input int k, input logic b);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk[0], kk[3:1], b};
  endfunction

  // One clock: sample #1 after the rising edge and run the strobe monitor.
  task automatic tick();
    logic [4:0] wr;
    @(posedge prog_clk);
    #1;
    cyc++;
    wr = {cfg_address, cfg_data_in};
    if (hold_pend) begin
      check("hold_enable_low", 32'(cfg_enable), 32'(0));
      check("hold_addr_data", 32'(wr), 32'(hold_exp));
      hold_pend = 1'b0;
    end
    if (cfg_enable) begin
      n_strobe++;
      check("strobe_one_cycle", 32'(prev_en), 32'(0));
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: addr/data %0h with empty scoreboard (cycle %0d)", wr, cyc);
      end else begin
        hold_exp = sb.pop_front();
        check("strobe_addr_data", 32'(wr), 32'(hold_exp));
        check("setup_addr_data", 32'(prev_wr), 32'(hold_exp));
        hold_pend = 1'b1;
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      check("done_one_cycle", 32'(prev_done), 32'(0));
    end
    prev_en   = cfg_enable;
    prev_done = done;
    prev_wr   = wr;
  endtask

  // Offer bit k; with gap>0 the source idles for gap cycles inside FETCH first.
  task automatic feed_bit(input logic b, input int k, input int gap, input logic spam);
    int w;
    if (gap > 0) begin
      w = 0;
      while (!bs_ready && w < 20) begin
        start = spam;
        tick();
        w++;
      end
      for (int g = 0; g < gap; g++) begin
        bs_valid = 1'b0;
        start    = spam;
        tick();
        check("ready_held_in_fetch", 32'(bs_ready), 32'(1));
      end
    end
    bs_valid = 1'b1;
    bs_data  = b;
    w = 0;
    while (!bs_ready && w < 20) begin
      start = spam;
      tick();
      w++;
    end
    if (!bs_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: bit %0d never accepted", k);
    end else begin
      sb.push_back(exp_wr(k, b));
      start = spam;
      tick();
    end
    if (gap > 0) bs_valid = 1'b0;
  endtask

  // Complete load driven from one table record.
  task automatic do_load(input vec_t v);
    int s_cyc;
    int d0;
    int st0;
    int w;
    int exp_lat;
    d0  = n_done;
    st0 = n_strobe;
    exp_lat = 64 + 16 * v.gap;
`ifdef IO_CFG_PARITY_EN
    exp_lat = exp_lat + 1;
    check("error_held_idle", 32'(error), 32'(last_err));
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
    check("busy_after_start", 32'(busy), 32'(1));
`ifdef IO_CFG_PARITY_EN
    check("error_cleared_by_start", 32'(error), 32'(0));
`endif
    for (int k = 0; k < 16; k++) begin
      feed_bit(v.bits[k], k, v.gap, v.spam);
    end
    start    = 1'b0;
    bs_valid = 1'b0;
`ifdef IO_CFG_PARITY_EN
    w = 0;
    while (!bs_ready && w < 20) begin
      tick();
      w++;
    end
    bs_valid = 1'b1;
    bs_data  = v.par;
    tick();
    bs_valid = 1'b0;
`endif
    w = 0;
    while (n_done == d0 && w < 20) begin
      tick();
      w++;
    end
    check("done_seen", 32'(n_done - d0), 32'(1));
    check("done_latency", 32'(done_cyc - s_cyc), 32'(exp_lat));
    check("busy_low_in_done", 32'(busy), 32'(0));
    repeat (3) tick();
    check("single_done", 32'(n_done - d0), 32'(1));
    check("strobe_count", 32'(n_strobe - st0), 32'(16));
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    check("addr_data_retained", 32'({cfg_address, cfg_data_in}), 32'(exp_wr(15, v.bits[15])));
    check("idle_outputs", 32'({busy, bs_ready, cfg_enable, done}), 32'(0));
`ifdef IO_CFG_PARITY_EN
    check("parity_error", 32'(error), 32'(v.exp_err));
    last_err = v.exp_err;
`endif
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; n_strobe = 0; n_done = 0; done_cyc = 0;
    prev_en = 1'b0; prev_done = 1'b0; prev_wr = 5'd0; hold_pend = 1'b0; hold_exp = 5'd0;
    prog_rst_n = 1'b0; start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = 1'b0;
`ifdef IO_CFG_PARITY_EN
    last_err = 1'b0;
`endif

    vecs.push_back('{16'b1010_0000_1111_0011, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'hC3A5, 3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h5A3C, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h0001, 1, 1'b0, 1'b1, 1'b0});
`ifdef IO_CFG_PARITY_EN
    vecs.push_back('{16'hFFFF, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0003, 0, 1'b0, 1'b0, 1'b0});
`endif

    // Reset state, before any clock edge.
    #2;
    check("reset_outputs", 32'({cfg_enable, cfg_address, cfg_data_in, bs_ready, busy, done}), 32'(0));
`ifdef IO_CFG_PARITY_EN
    check("reset_error", 32'(error), 32'(0));
`endif
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_reset", 32'({busy, bs_ready, cfg_enable, done}), 32'(0));

    // start together with abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'({busy, bs_ready}), 32'(0));
    tick();
    check("start_abort_stays_idle", 32'({busy, bs_ready}), 32'(0));

    // Reset asserted during the strobe of bit 5 clears outputs at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) feed_bit(1'b1, k, 0, 1'b0);
    bs_valid = 1'b0;
    tick();
    check("strobe_bit5_before_reset", 32'(cfg_enable), 32'(1));
    #2;
    prog_rst_n = 1'b0;
    hold_pend  = 1'b0;
    #1;
    check("async_reset_outputs", 32'({cfg_enable, cfg_address, cfg_data_in, bs_ready, busy, done}), 32'(0));
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    prev_en = 1'b0; prev_done = 1'b0; prev_wr = 5'd0;
    tick();

    // Table-driven full loads; the first one also shows a reload from address 0.
    for (int i = 0; i < vecs.size(); i++) begin
      do_load(vecs[i]);
    end

    // Abort during the strobe of bit 7.
    begin
      int d0;
      d0 = n_done;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) feed_bit(1'b1, k, 0, 1'b0);
      tick();
      check("strobe_bit7_before_abort", 32'(cfg_enable), 32'(1));
      abort     = 1'b1;
      bs_valid  = 1'b0;
      hold_pend = 1'b0;
      tick();
      abort = 1'b0;
      check("abort_cuts_strobe", 32'(cfg_enable), 32'(0));
      check("abort_clears_addr_data", 32'({cfg_address, cfg_data_in}), 32'(0));
      check("abort_to_idle", 32'({busy, bs_ready, done}), 32'(0));
      repeat (5) tick();
      check("abort_no_done", 32'(n_done - d0), 32'(0));
      check("abort_scoreboard", 32'(sb.size()), 32'(0));
    end

    // Recovery load after the abort.
    do_load(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
